io_err_monitor: RTL
===================

Name: io_err_monitor

Overview:
- Parametrised successor of the bidirectional-IO error detector; sits beside the top-level pad wrapper.
- Each cycle, checks the IO output-enable vector against an expected configuration.
- Flags any output bit driven high while its enable is low.
- Adds a glitch filter, a clear input, first-fault capture, an offending-bit snapshot, a saturating error-cycle counter and a rising-edge pulse.

Parameters:
- W, 8: width of the uio_oe / uio_out vectors.
- OE_EXP, 8'b10001000 (W bits): required uio_oe value.
- FILT, 1: consecutive raw-error cycles needed to latch a fault (must be >= 1).
- CNT_W, 8: width of the error-cycle counter.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous, active-low reset
- clr_i  in  1  synchronous clear of all sticky/captured state
- uio_oe  in  W  observed output enables
- uio_out  in  W  observed output values
- err_o  out  1  sticky fault flag
- err_pulse_o  out  1  one-cycle pulse on err_o rising
- err_seen_o  out  2  sticky OR of raw causes since clear; bit0 = config, bit1 = unexpected output
- err_first_o  out  2  causes present on the fault-latching cycle
- err_bits_o  out  W  offending-bit mask on the fault-latching cycle
- err_cnt_o  out  CNT_W  saturating count of raw-error cycles since clear

Behaviour:
- Clock and reset: clk; nreset is synchronous and active-low.
- Reset: all outputs 0; state OK; run counter 0.
- Combinational terms:
  - conf = (uio_oe != OE_EXP)
  - unexp = |(~uio_oe & uio_out)
  - raw = conf | unexp
  - bits = (uio_oe ^ OE_EXP) | (~uio_oe & uio_out)
- State machine, states OK / PEND / FAULT; run counter width clog2(FILT+1):
  - OK or PEND, raw=1, run==FILT-1: next state FAULT; run<=0; err_first_o<={unexp,conf}; err_bits_o<=bits.
  - OK or PEND, raw=1, run<FILT-1: next state PEND; run<=run+1.
  - OK or PEND, raw=0: next state OK; run<=0. A gap restarts filtering.
  - FAULT: held regardless of raw; err_first_o and err_bits_o frozen; later faults never overwrite them.
- Outputs:
  - err_o = (state==FAULT), registered.
  - Latency: with FILT=1, err_o rises the cycle after the first raw cycle. Generally, the cycle after the FILT-th consecutive raw cycle.
  - err_pulse_o is high only on the first cycle err_o is high after leaving OK/PEND.
  - err_seen_o <= err_seen_o | {unexp,conf} every cycle. Filtered glitches are recorded.
  - err_cnt_o increments on every raw cycle in any state and saturates at 2^CNT_W-1 (no wrap).
- clr_i=1 (nreset low has priority over clr_i):
  - Next state OK; run, err_seen_o, err_first_o, err_bits_o, err_cnt_o <= 0.
  - clr_i wins over a simultaneous raw; that cycle's raw is neither counted nor accumulated.
  - err_pulse_o is 0 the cycle after clr_i.
- nreset low mid-filter or mid-fault: immediate return to reset values on that edge.
- Inputs are already synchronous to clk; no synchronisers.

Test Plan:
- FILT=1, reset then uio_oe=0x88, uio_out=0x00 for 10 cycles -> err_o=0, err_cnt_o=0, err_seen_o=0.
- FILT=1, one cycle uio_oe=0x88, uio_out=0x01 -> next cycle: err_o=1, err_pulse_o=1, err_first_o=2'b10, err_bits_o=0x01, err_cnt_o=1. Following cycle: err_pulse_o=0; err_o stays 1 after inputs return legal.
- FILT=3, uio_oe=0x80 for 2 cycles, legal 1 cycle, 0x80 for 3 cycles:
  - err_o stays 0 after the first burst.
  - err_o rises the cycle after the 3rd cycle of the second burst.
  - err_first_o=2'b01, err_bits_o=0x08, err_seen_o=2'b01, err_cnt_o=5.
- In FAULT, apply uio_oe=0x00, uio_out=0xFF -> err_first_o and err_bits_o unchanged; err_seen_o=2'b11; err_cnt_o keeps incrementing.
- CNT_W=2, hold raw error 6 cycles -> err_cnt_o saturates at 3.
- clr_i asserted with raw=1 -> next cycle all outputs 0, state OK. Then 1 raw cycle (FILT=1) -> err_o=1 and err_pulse_o=1 again.
- nreset low during PEND (FILT=3, run=2) -> all outputs 0; 2 further raw cycles do not set err_o.

Source files
------------

// File: rtl/io_err_monitor.sv
// rtl/io_err_monitor.sv - filtered IO output-enable error monitor with capture and counting
module io_err_monitor #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   OE_EXP = 8'b10001000,
    parameter int             FILT   = 1,
    parameter int             CNT_W  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr_i,
    input  logic [W-1:0]     uio_oe,
    input  logic [W-1:0]     uio_out,
    output logic             err_o,
    output logic             err_pulse_o,
    output logic [1:0]       err_seen_o,
    output logic [1:0]       err_first_o,
    output logic [W-1:0]     err_bits_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int RW = $clog2(FILT + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(FILT - 1);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_PEND  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] run;
    logic [RW-1:0] run_next;
    logic          capture;

    logic          conf;
    logic          unexp;
    logic          raw;
    logic [W-1:0]  bits;

    // Raw error causes and offending-bit mask for the current cycle
    always_comb begin
        conf  = (uio_oe != OE_EXP);
        unexp = |(~uio_oe & uio_out);
        raw   = conf | unexp;
        bits  = (uio_oe ^ OE_EXP) | (~uio_oe & uio_out);
    end

    // Glitch filter: FILT consecutive raw cycles move to FAULT; a clean cycle restarts it
    always_comb begin
        state_next = state;
        run_next   = run;
        capture    = 1'b0;
        if (state != ST_FAULT) begin
            if (raw) begin
                if (run == RUN_LAST) begin
                    state_next = ST_FAULT;
                    run_next   = '0;
                    capture    = 1'b1;
                end else begin
                    state_next = ST_PEND;
                    run_next   = run + RW'(1);
                end
            end else begin
                state_next = ST_OK;
                run_next   = '0;
            end
        end
        if (clr_i) begin
            state_next = ST_OK;
            run_next   = '0;
            capture    = 1'b0;
        end
    end

    // State and filter run register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_OK;
            run   <= '0;
        end else begin
            state <= state_next;
            run   <= run_next;
        end
    end

    // Sticky cause history, first-fault capture, edge pulse and saturating counter
    always_ff @(posedge clk) begin
        if (!nreset || clr_i) begin
            err_pulse_o <= 1'b0;
            err_seen_o  <= '0;
            err_first_o <= '0;
            err_bits_o  <= '0;
            err_cnt_o   <= '0;
        end else begin
            err_pulse_o <= capture;
            err_seen_o  <= err_seen_o | {unexp, conf};
            if (capture) begin
                err_first_o <= {unexp, conf};
                err_bits_o  <= bits;
            end
            if (raw && (err_cnt_o != {CNT_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
        end
    end

    assign err_o = (state == ST_FAULT);

endmodule
